// File: rtl/gemm_addr_gen.sv
// GEMM index generator: walks uops inside iter_out x iter_in loops, emits {acc,inp,wgt} tuples.
// Optional GEMM_ADDR_BOUND_CHK_EN adds a sticky addr_err flag for index sums that wrap.
module gemm_addr_gen #(
    parameter int ACC_IDX_WIDTH = 12,
    parameter int INP_IDX_WIDTH = 12,
    parameter int WGT_IDX_WIDTH = 11,
    parameter int UOP_IDX_WIDTH = 13,
    parameter int ITER_WIDTH    = 14
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 insn_valid,
    output logic                                                 insn_ready,
    input  logic [UOP_IDX_WIDTH-1:0]                             uop_bgn,
    input  logic [UOP_IDX_WIDTH-1:0]                             uop_end,
    input  logic [ITER_WIDTH-1:0]                                iter_out,
    input  logic [ITER_WIDTH-1:0]                                iter_in,
    input  logic [ACC_IDX_WIDTH-1:0]                             dst_fac_out,
    input  logic [ACC_IDX_WIDTH-1:0]                             dst_fac_in,
    input  logic [INP_IDX_WIDTH-1:0]                             src_fac_out,
    input  logic [INP_IDX_WIDTH-1:0]                             src_fac_in,
    input  logic [WGT_IDX_WIDTH-1:0]                             wgt_fac_out,
    input  logic [WGT_IDX_WIDTH-1:0]                             wgt_fac_in,
    output logic                                                 uop_rd_en,
    output logic [UOP_IDX_WIDTH-1:0]                             uop_addr,
    input  logic [ACC_IDX_WIDTH+INP_IDX_WIDTH+WGT_IDX_WIDTH-1:0] uop_data,
    output logic                                                 addr_valid,
    input  logic                                                 addr_ready,
    output logic [ACC_IDX_WIDTH-1:0]                             acc_addr,
    output logic [INP_IDX_WIDTH-1:0]                             inp_addr,
    output logic [WGT_IDX_WIDTH-1:0]                             wgt_addr,
    output logic                                                 addr_last,
    output logic                                                 done
`ifdef GEMM_ADDR_BOUND_CHK_EN
    ,
    output logic                                                 addr_err
`endif
);

    // Sums are only kept wider than the index when the overflow check needs the carry bits.
`ifdef GEMM_ADDR_BOUND_CHK_EN
    localparam int ACC_SUM_W = ACC_IDX_WIDTH + ITER_WIDTH + 2;
    localparam int INP_SUM_W = INP_IDX_WIDTH + ITER_WIDTH + 2;
    localparam int WGT_SUM_W = WGT_IDX_WIDTH + ITER_WIDTH + 2;
`else
    localparam int ACC_SUM_W = ACC_IDX_WIDTH;
    localparam int INP_SUM_W = INP_IDX_WIDTH;
    localparam int WGT_SUM_W = WGT_IDX_WIDTH;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE
    } state_e;

    state_e                     state_q;
    logic                       insn_ready_q;
    logic                       uop_rd_en_q;
    logic [UOP_IDX_WIDTH-1:0]   uop_addr_q;
    logic                       addr_valid_q;
    logic [ACC_IDX_WIDTH-1:0]   acc_addr_q;
    logic [INP_IDX_WIDTH-1:0]   inp_addr_q;
    logic [WGT_IDX_WIDTH-1:0]   wgt_addr_q;
    logic                       addr_last_q;
    logic                       done_q;

    logic [UOP_IDX_WIDTH-1:0]   uop_bgn_q, uop_end_q, u_q;
    logic [ITER_WIDTH-1:0]      iter_out_q, iter_in_q, o_q, i_q;
    logic [ACC_IDX_WIDTH-1:0]   dst_fac_out_q, dst_fac_in_q;
    logic [INP_IDX_WIDTH-1:0]   src_fac_out_q, src_fac_in_q;
    logic [WGT_IDX_WIDTH-1:0]   wgt_fac_out_q, wgt_fac_in_q;

    logic [ACC_IDX_WIDTH-1:0]   uop_acc;
    logic [INP_IDX_WIDTH-1:0]   uop_inp;
    logic [WGT_IDX_WIDTH-1:0]   uop_wgt;
    logic [ACC_SUM_W-1:0]       acc_sum;
    logic [INP_SUM_W-1:0]       inp_sum;
    logic [WGT_SUM_W-1:0]       wgt_sum;
    logic [ACC_IDX_WIDTH-1:0]   acc_addr_d;
    logic [INP_IDX_WIDTH-1:0]   inp_addr_d;
    logic [WGT_IDX_WIDTH-1:0]   wgt_addr_d;
    logic                       u_last, i_last, o_last, insn_empty;
    logic [UOP_IDX_WIDTH-1:0]   u_d;
    logic [ITER_WIDTH-1:0]      i_d, o_d;

    assign uop_acc = uop_data[ACC_IDX_WIDTH-1:0];
    assign uop_inp = uop_data[ACC_IDX_WIDTH+INP_IDX_WIDTH-1:ACC_IDX_WIDTH];
    assign uop_wgt = uop_data[ACC_IDX_WIDTH+INP_IDX_WIDTH+WGT_IDX_WIDTH-1:ACC_IDX_WIDTH+INP_IDX_WIDTH];

    assign insn_empty = (iter_out == '0) || (iter_in == '0) || (uop_end <= uop_bgn);

    always_comb begin
        acc_sum = ACC_SUM_W'(uop_acc)
                + ACC_SUM_W'(o_q) * ACC_SUM_W'(dst_fac_out_q)
                + ACC_SUM_W'(i_q) * ACC_SUM_W'(dst_fac_in_q);
        inp_sum = INP_SUM_W'(uop_inp)
                + INP_SUM_W'(o_q) * INP_SUM_W'(src_fac_out_q)
                + INP_SUM_W'(i_q) * INP_SUM_W'(src_fac_in_q);
        wgt_sum = WGT_SUM_W'(uop_wgt)
                + WGT_SUM_W'(o_q) * WGT_SUM_W'(wgt_fac_out_q)
                + WGT_SUM_W'(i_q) * WGT_SUM_W'(wgt_fac_in_q);
        acc_addr_d = acc_sum[ACC_IDX_WIDTH-1:0];
        inp_addr_d = inp_sum[INP_IDX_WIDTH-1:0];
        wgt_addr_d = wgt_sum[WGT_IDX_WIDTH-1:0];
    end

    // Loop advance: u is innermost, then i, then o.
    always_comb begin
        u_last = (u_q + UOP_IDX_WIDTH'(1)) == uop_end_q;
        i_last = (i_q + ITER_WIDTH'(1)) == iter_in_q;
        o_last = (o_q + ITER_WIDTH'(1)) == iter_out_q;
        u_d    = u_last ? uop_bgn_q : u_q + UOP_IDX_WIDTH'(1);
        i_d    = i_q;
        o_d    = o_q;
        if (u_last) begin
            i_d = i_last ? '0 : i_q + ITER_WIDTH'(1);
            if (i_last) begin
                o_d = o_q + ITER_WIDTH'(1);
            end
        end
    end

`ifdef GEMM_ADDR_BOUND_CHK_EN
    logic addr_err_q;
    logic sum_ovf;
    assign sum_ovf = (acc_sum[ACC_SUM_W-1:ACC_IDX_WIDTH] != '0)
                  || (inp_sum[INP_SUM_W-1:INP_IDX_WIDTH] != '0)
                  || (wgt_sum[WGT_SUM_W-1:WGT_IDX_WIDTH] != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err_q <= 1'b0;
        end else if (state_q == S_IDLE && insn_valid && insn_ready_q) begin
            addr_err_q <= 1'b0;
        end else if (state_q == S_LOAD && sum_ovf) begin
            addr_err_q <= 1'b1;
        end
    end

    assign addr_err = addr_err_q;
`endif

    // NOTE: non-blocking assignments only, so every branch below reads pre-edge register values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            insn_ready_q  <= 1'b1;
            uop_rd_en_q   <= 1'b0;
            uop_addr_q    <= '0;
            addr_valid_q  <= 1'b0;
            acc_addr_q    <= '0;
            inp_addr_q    <= '0;
            wgt_addr_q    <= '0;
            addr_last_q   <= 1'b0;
            done_q        <= 1'b0;
            uop_bgn_q     <= '0;
            uop_end_q     <= '0;
            iter_out_q    <= '0;
            iter_in_q     <= '0;
            dst_fac_out_q <= '0;
            dst_fac_in_q  <= '0;
            src_fac_out_q <= '0;
            src_fac_in_q  <= '0;
            wgt_fac_out_q <= '0;
            wgt_fac_in_q  <= '0;
            u_q           <= '0;
            i_q           <= '0;
            o_q           <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (insn_valid && insn_ready_q) begin
                        uop_bgn_q     <= uop_bgn;
                        uop_end_q     <= uop_end;
                        iter_out_q    <= iter_out;
                        iter_in_q     <= iter_in;
                        dst_fac_out_q <= dst_fac_out;
                        dst_fac_in_q  <= dst_fac_in;
                        src_fac_out_q <= src_fac_out;
                        src_fac_in_q  <= src_fac_in;
                        wgt_fac_out_q <= wgt_fac_out;
                        wgt_fac_in_q  <= wgt_fac_in;
                        u_q           <= uop_bgn;
                        i_q           <= '0;
                        o_q           <= '0;
                        if (insn_empty) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q      <= S_FETCH;
                            insn_ready_q <= 1'b0;
                            uop_rd_en_q  <= 1'b1;
                            uop_addr_q   <= uop_bgn;
                        end
                    end
                end
                S_FETCH: begin
                    uop_rd_en_q <= 1'b0;
                    state_q     <= S_LOAD;
                end
                S_LOAD: begin
                    acc_addr_q   <= acc_addr_d;
                    inp_addr_q   <= inp_addr_d;
                    wgt_addr_q   <= wgt_addr_d;
                    addr_last_q  <= u_last && i_last && o_last;
                    addr_valid_q <= 1'b1;
                    state_q      <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (addr_ready) begin
                        addr_valid_q <= 1'b0;
                        addr_last_q  <= 1'b0;
                        if (addr_last_q) begin
                            done_q       <= 1'b1;
                            insn_ready_q <= 1'b1;
                            state_q      <= S_IDLE;
                        end else begin
                            u_q         <= u_d;
                            i_q         <= i_d;
                            o_q         <= o_d;
                            uop_rd_en_q <= 1'b1;
                            uop_addr_q  <= u_d;
                            state_q     <= S_FETCH;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign insn_ready = insn_ready_q;
    assign uop_rd_en  = uop_rd_en_q;
    assign uop_addr   = uop_addr_q;
    assign addr_valid = addr_valid_q;
    assign acc_addr   = acc_addr_q;
    assign inp_addr   = inp_addr_q;
    assign wgt_addr   = wgt_addr_q;
    assign addr_last  = addr_last_q;
    assign done       = done_q;

endmodule

// File: tb/tb_gemm_addr_gen.sv
// Directed bench for gemm_addr_gen: table of instructions with hand-computed tuples,
// plus stall and mid-operation reset sequences. Checks addr_err when GEMM_ADDR_BOUND_CHK_EN is set.
module tb_gemm_addr_gen;

    localparam int AW = 12;
    localparam int IW = 12;
    localparam int WW = 11;
    localparam int UW = 13;
    localparam int TW = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              insn_valid, insn_ready;
    logic [UW-1:0]     uop_bgn, uop_end, uop_addr;
    logic [TW-1:0]     iter_out, iter_in;
    logic [AW-1:0]     dst_fac_out, dst_fac_in, acc_addr;
    logic [IW-1:0]     src_fac_out, src_fac_in, inp_addr;
    logic [WW-1:0]     wgt_fac_out, wgt_fac_in, wgt_addr;
    logic              uop_rd_en, addr_valid, addr_ready, addr_last, done;
    logic [AW+IW+WW-1:0] uop_data;
`ifdef GEMM_ADDR_BOUND_CHK_EN
    logic              addr_err;
`endif

    always #5 clk = ~clk;

    gemm_addr_gen dut (
        .clk(clk), .rst_n(rst_n),
        .insn_valid(insn_valid), .insn_ready(insn_ready),
        .uop_bgn(uop_bgn), .uop_end(uop_end),
        .iter_out(iter_out), .iter_in(iter_in),
        .dst_fac_out(dst_fac_out), .dst_fac_in(dst_fac_in),
        .src_fac_out(src_fac_out), .src_fac_in(src_fac_in),
        .wgt_fac_out(wgt_fac_out), .wgt_fac_in(wgt_fac_in),
        .uop_rd_en(uop_rd_en), .uop_addr(uop_addr), .uop_data(uop_data),
        .addr_valid(addr_valid), .addr_ready(addr_ready),
        .acc_addr(acc_addr), .inp_addr(inp_addr), .wgt_addr(wgt_addr),
        .addr_last(addr_last), .done(done)
`ifdef GEMM_ADDR_BOUND_CHK_EN
        , .addr_err(addr_err)
`endif
    );

    // Synchronous uop memory: data valid the cycle after the read strobe.
    logic [AW+IW+WW-1:0] umem [0:15];
    always @(posedge clk) if (uop_rd_en) uop_data <= umem[uop_addr[3:0]];

    typedef struct {
        int io, ii, ub, ue;
        int dfo, dfi, sfo, sfi, wfo, wfi;
        int n;
        int fa, fi, fw;
        int la, li, lw;
        int err;
    } vec_t;

    vec_t vecs [7];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rec_a [64], rec_i [64], rec_w [64], rec_l [64];
    int   rec_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_fields(input int vi);
        vec_t v;
        v = vecs[vi];
        iter_out    = TW'(v.io);
        iter_in     = TW'(v.ii);
        uop_bgn     = UW'(v.ub);
        uop_end     = UW'(v.ue);
        dst_fac_out = AW'(v.dfo);
        dst_fac_in  = AW'(v.dfi);
        src_fac_out = IW'(v.sfo);
        src_fac_in  = IW'(v.sfi);
        wgt_fac_out = WW'(v.wfo);
        wgt_fac_in  = WW'(v.wfi);
    endtask

    task automatic scramble_fields();
        iter_out    = '1;
        iter_in     = '0;
        uop_bgn     = UW'(3);
        uop_end     = UW'(1);
        dst_fac_out = '1;
        dst_fac_in  = '1;
        src_fac_out = '1;
        src_fac_in  = '1;
        wgt_fac_out = '1;
        wgt_fac_in  = '1;
    endtask

    // Runs one instruction; stall_at >= 0 holds addr_ready low 5 cycles on that tuple.
    task automatic run_vec(input int vi, input int stall_at);
        vec_t v;
        int cyc, rd_cnt, busy_rdy, last_cnt, done_cyc, first_cyc;
        int stall_left, stable_err, ha, hi, hw, exp_done;
        v = vecs[vi];
        @(negedge clk);
        check($sformatf("v%0d_ready_before", vi), insn_ready, 1);
        drive_fields(vi);
        insn_valid = 1'b1;
        addr_ready = 1'b1;
        @(posedge clk);
        #1;
        insn_valid = 1'b0;
        scramble_fields();
        rec_n = 0; cyc = 0; rd_cnt = 0; busy_rdy = 0; last_cnt = 0;
        done_cyc = -1; first_cyc = -1; stall_left = 5; stable_err = 0;
        ha = 0; hi = 0; hw = 0;
        while (done_cyc < 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (uop_rd_en) rd_cnt++;
            if (done) begin
                done_cyc = cyc;
                check($sformatf("v%0d_ready_at_done", vi), insn_ready, 1);
`ifdef GEMM_ADDR_BOUND_CHK_EN
                check($sformatf("v%0d_addr_err", vi), addr_err, v.err);
`endif
            end else if (insn_ready) begin
                busy_rdy++;
            end
            if (addr_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (rec_n == stall_at && stall_left > 0) begin
                    if (stall_left == 5) begin
                        ha = acc_addr; hi = inp_addr; hw = wgt_addr;
                    end else if (acc_addr != AW'(ha) || inp_addr != IW'(hi) || wgt_addr != WW'(hw)) begin
                        stable_err++;
                    end
                    stall_left--;
                    addr_ready = 1'b0;
                end else begin
                    if (rec_n == stall_at &&
                        (acc_addr != AW'(ha) || inp_addr != IW'(hi) || wgt_addr != WW'(hw)))
                        stable_err++;
                    rec_a[rec_n] = acc_addr;
                    rec_i[rec_n] = inp_addr;
                    rec_w[rec_n] = wgt_addr;
                    rec_l[rec_n] = addr_last;
                    if (addr_last) last_cnt++;
                    if (rec_n < 63) rec_n++;
                    addr_ready = 1'b1;
                end
            end else begin
                if (rec_n == stall_at && stall_left < 5) stable_err++;
                addr_ready = 1'b1;
            end
        end
        exp_done = (v.n == 0) ? 1 : 3 * v.n + 1 + ((stall_at >= 0) ? 5 : 0);
        check($sformatf("v%0d_done_cycle", vi), done_cyc, exp_done);
        check($sformatf("v%0d_tuple_count", vi), rec_n, v.n);
        check($sformatf("v%0d_uop_reads", vi), rd_cnt, v.n);
        check($sformatf("v%0d_busy_ready", vi), busy_rdy, 0);
        check($sformatf("v%0d_last_count", vi), last_cnt, (v.n > 0) ? 1 : 0);
        if (v.n > 0 && rec_n > 0) begin
            check($sformatf("v%0d_first_latency", vi), first_cyc, 3);
            check($sformatf("v%0d_first_acc", vi), rec_a[0], v.fa);
            check($sformatf("v%0d_first_inp", vi), rec_i[0], v.fi);
            check($sformatf("v%0d_first_wgt", vi), rec_w[0], v.fw);
            check($sformatf("v%0d_last_acc", vi), rec_a[rec_n-1], v.la);
            check($sformatf("v%0d_last_inp", vi), rec_i[rec_n-1], v.li);
            check($sformatf("v%0d_last_wgt", vi), rec_w[rec_n-1], v.lw);
            check($sformatf("v%0d_last_flag", vi), rec_l[rec_n-1], 1);
        end
        if (stall_at >= 0) check($sformatf("v%0d_stall_stable", vi), stable_err, 0);
        @(negedge clk);
        check($sformatf("v%0d_done_pulse", vi), done, 0);
    endtask

    initial begin
        int wait_cyc;
        // io ii ub ue | dfo dfi sfo sfi wfo wfi | n | first acc/inp/wgt | last acc/inp/wgt | err
        vecs[0] = '{1, 1, 0, 1,   0, 0, 0, 0, 0, 0,      1,  5, 7, 9,       5, 7, 9,        0};
        vecs[1] = '{2, 3, 4, 6,   16, 1, 8, 2, 0, 1,     12, 0, 0, 0,       18, 12, 2,      0};
        vecs[2] = '{3, 2, 8, 11,  100, 7, 3, 5, 10, 20,  18, 200, 100, 3,   206, 4011, 2040, 1};
        vecs[3] = '{1, 2, 12, 13, 0, 10, 0, 0, 0, 0,     2,  4090, 0, 0,    4, 0, 0,        1};
        vecs[4] = '{1, 0, 0, 1,   0, 0, 0, 0, 0, 0,      0,  0, 0, 0,       0, 0, 0,        0};
        vecs[5] = '{2, 2, 6, 5,   0, 0, 0, 0, 0, 0,      0,  0, 0, 0,       0, 0, 0,        0};
        vecs[6] = '{0, 3, 0, 1,   0, 0, 0, 0, 0, 0,      0,  0, 0, 0,       0, 0, 0,        0};

        for (int k = 0; k < 16; k++) umem[k] = '0;
        umem[0]  = {11'd9,    12'd7,    12'd5};
        umem[8]  = {11'd3,    12'd100,  12'd200};
        umem[9]  = {11'd1,    12'd50,   12'd10};
        umem[10] = {11'd2000, 12'd4000, 12'd4095};
        umem[12] = {11'd0,    12'd0,    12'd4090};

        rst_n = 1'b0;
        insn_valid = 1'b0;
        addr_ready = 1'b0;
        scramble_fields();
        #12;
        check("rst_insn_ready", insn_ready, 1);
        check("rst_addr_valid", addr_valid, 0);
        check("rst_uop_rd_en", uop_rd_en, 0);
        check("rst_done", done, 0);
        check("rst_acc_addr", acc_addr, 0);
        check("rst_addr_last", addr_last, 0);
`ifdef GEMM_ADDR_BOUND_CHK_EN
        check("rst_addr_err", addr_err, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) run_vec(v, -1);

        // Backpressure on the third tuple of the 2x3 instruction.
        run_vec(1, 2);
        check("stall_t2_acc", rec_a[2], 1);
        check("stall_t2_inp", rec_i[2], 2);
        check("stall_t2_wgt", rec_w[2], 1);
        check("stall_t3_acc", rec_a[3], 1);

        // Reset while a tuple is presented, then a fresh instruction.
        @(negedge clk);
        drive_fields(2);
        insn_valid = 1'b1;
        addr_ready = 1'b0;
        @(posedge clk);
        #1;
        insn_valid = 1'b0;
        wait_cyc = 0;
        while (!addr_valid && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("rst_mid_valid_seen", addr_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_addr_valid", addr_valid, 0);
        check("rst_mid_acc_addr", acc_addr, 0);
        check("rst_mid_insn_ready", insn_ready, 1);
        check("rst_mid_uop_rd_en", uop_rd_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(2, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
